multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Multi-cycle control unit for the Mini-MIPS core.
- Sequences fetch, decode, execute, memory and writeback for the four instruction classes: R, I, J and FP.
- Consumes the decoded type/op fields from the instruction-decode stage.
- Drives datapath enables: PC, IR, ALU, data memory, integer and FP register files.

Parameters:
- LW_OP, 5'd16, I-type op code for load word
- SW_OP, 5'd17, I-type op code for store word
- BR_LO, 5'd18, lowest I-type branch op code (inclusive)
- BR_HI, 5'd23, highest I-type branch op code (inclusive)
- TIMEOUT, 16, maximum wait cycles for any ready/done handshake before entering ERROR
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  current IR contents; used only to detect HALT (32'hFFFFFFFF)
- type  in  2  decoded class: 0=R, 1=I, 2=J, 3=FP
- op  in  5  decoded op; for J-type, op[0]=1 means jump-and-link
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- fp_done  in  1  FP unit result valid
- branch_taken  in  1  ALU branch condition, sampled in EXEC
- ir_write  out  1  latch instruction into IR
- pc_write  out  1  update PC
- pc_src  out  2  0=PC+1, 1=branch target, 2=jump address
- alu_start  out  1  ALU operand/op latch strobe
- mem_read  out  1  data memory read request
- mem_write  out  1  data memory write request
- reg_write  out  1  integer register file write
- link_write  out  1  write PC+1 to r31
- fp_start  out  1  FP unit start strobe
- fp_reg_write  out  1  FP register file write
- halted  out  1  core stopped
- error  out  1  handshake timeout occurred
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (async, rst_n low): state=FETCH; retired=0; wait counter=0. All outputs 0 while in reset; pc_src=0.
- Outputs are Moore-decoded from state, except the pc_write/pc_src qualifiers in EXEC, which depend on branch_taken.
- FETCH: mem_read-style wait on imem_ready.
  - imem_ready=1 -> ir_write=1, pc_write=1, pc_src=0 for that cycle, next DECODE.
- DECODE: 1 cycle, no strobes.
  - instr==32'hFFFFFFFF -> HALT.
  - else type=3 -> FP_EXEC.
  - else -> EXEC.
- EXEC: alu_start=1 for exactly 1 cycle.
  - R-type -> WB.
  - I-type, op==LW_OP or SW_OP -> MEM.
  - I-type, op in [BR_LO,BR_HI] -> FETCH; pc_write=branch_taken, pc_src=1. Counts as retired.
  - Other I-type -> WB.
  - J-type -> pc_write=1, pc_src=2, link_write=op[0], next FETCH. Retired.
- MEM: mem_read=(op==LW_OP) or mem_write=(op==SW_OP), held high until dmem_ready.
  - On dmem_ready: load -> WB; store -> FETCH, retired.
- FP_EXEC: fp_start=1 on entry cycle only, then wait for fp_done.
  - fp_done -> WB.
  - fp_done is ignored in any other state.
- WB: 1 cycle.
  - reg_write=1 if type!=3.
  - fp_reg_write=1 if type=3.
  - Next FETCH; retired++.
- Retirement: retired increments on the cycle leaving WB, on branch/J exit from EXEC, and on store exit from MEM. It wraps modulo 2^CNT_W.
- Timeout: the wait counter resets on entry to FETCH, MEM and FP_EXEC, and increments each cycle the awaited signal is low.
  - Reaching TIMEOUT -> ERROR.
  - Ready arriving on the same cycle the counter hits TIMEOUT wins; the transition proceeds normally.
- HALT: halted=1, all strobes 0; absorbing until reset.
- ERROR: error=1, halted=1, absorbing until reset.
- Reset mid-operation: returns to FETCH immediately. In-flight mem_read/mem_write drop asynchronously. Partial instructions are not retired.
- type/op must be stable from DECODE through instruction completion; the FSM does not latch them.

Test Plan:
- R-type add (type=0), imem_ready and no waits -> FETCH,DECODE,EXEC,WB in 4 cycles; reg_write pulses once; retired 0->1.
- LW (type=1, op=16), dmem_ready delayed 3 cycles -> mem_read high 4 cycles, then reg_write=1; total 8 cycles; retired=1.
- Branch op=18:
  - branch_taken=1 -> pc_write=1, pc_src=1 in EXEC.
  - branch_taken=0 -> pc_write=0.
  - Both return to FETCH.
- J-type with op[0]=1 -> pc_src=2, pc_write=1, link_write=1 in EXEC.
- FP op (type=3), fp_done after 5 cycles -> fp_start single pulse, then fp_reg_write=1, reg_write=0.
- Stall and halt:
  - dmem_ready never asserted with TIMEOUT=16 -> error=1 after 16 MEM cycles.
  - instr=32'hFFFFFFFF -> halted=1 after DECODE.
  - rst_n low mid-MEM -> mem_read=0 immediately, state FETCH, retired=0.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control/datapath bundle for the Mini-MIPS multi-cycle control unit.
// The master side is the control FSM; the slave side is the datapath and memories.
interface multicycle_control_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  // decode and handshake inputs to the controller
  logic [31:0]      instr;
  logic [1:0]       instr_type;
  logic [4:0]       op;
  logic             imem_ready;
  logic             dmem_ready;
  logic             fp_done;
  logic             branch_taken;

  // datapath enables driven by the controller
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             alu_start;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             link_write;
  logic             fp_start;
  logic             fp_reg_write;
  logic             halted;
  logic             error;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr, instr_type, op, imem_ready, dmem_ready, fp_done, branch_taken,
    output ir_write, pc_write, pc_src, alu_start, mem_read, mem_write, reg_write,
           link_write, fp_start, fp_reg_write, halted, error, retired
  );

  modport slave (
    output instr, instr_type, op, imem_ready, dmem_ready, fp_done, branch_taken,
    input  ir_write, pc_write, pc_src, alu_start, mem_read, mem_write, reg_write,
           link_write, fp_start, fp_reg_write, halted, error, retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit for Mini-MIPS: fetch/decode/exec/mem/wb sequencing for
// R, I, J and FP classes, with handshake timeouts and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter logic [4:0]  LW_OP   = 5'd16,
  parameter logic [4:0]  SW_OP   = 5'd17,
  parameter logic [4:0]  BR_LO   = 5'd18,
  parameter logic [4:0]  BR_HI   = 5'd23,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_control_fsm_if.master bus
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_FP_EXEC,
    S_WB,
    S_HALT,
    S_ERROR
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WCNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   retired_q;
  logic               retire;
  logic               wait_last;

  logic               alu_start_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic               reg_write_q;
  logic               link_write_q;
  logic               fp_start_q;
  logic               fp_reg_write_q;
  logic               halted_q;
  logic               error_q;

  logic               is_i;
  logic               is_j;
  logic               is_fp;
  logic               is_ld;
  logic               is_st;
  logic               is_br;

  always_comb begin
    is_i  = (bus.instr_type == 2'd1);
    is_j  = (bus.instr_type == 2'd2);
    is_fp = (bus.instr_type == 2'd3);
    is_ld = is_i && (bus.op == LW_OP);
    is_st = is_i && (bus.op == SW_OP);
    is_br = is_i && (bus.op >= BR_LO) && (bus.op <= BR_HI);
  end

  // Last permitted wait cycle: a ready seen now still wins over the timeout.
  assign wait_last = (wait_cnt == WCNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (bus.imem_ready)  state_nxt = S_DECODE;
        else if (wait_last)  state_nxt = S_ERROR;
      end
      S_DECODE: begin
        if (bus.instr == '1) state_nxt = S_HALT;
        else if (is_fp)      state_nxt = S_FP_EXEC;
        else                 state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (is_j || is_br) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end else if (is_ld || is_st) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (is_st) begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end else begin
            state_nxt = S_WB;
          end
        end else if (wait_last) begin
          state_nxt = S_ERROR;
        end
      end
      S_FP_EXEC: begin
        if (bus.fp_done)     state_nxt = S_WB;
        else if (wait_last)  state_nxt = S_ERROR;
      end
      S_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      default: state_nxt = state;
    endcase
  end

  // Moore strobes are registered from the next state so they are valid for the
  // whole cycle the FSM spends in that state, and clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_FETCH;
      wait_cnt       <= '0;
      retired_q      <= '0;
      alu_start_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      reg_write_q    <= 1'b0;
      link_write_q   <= 1'b0;
      fp_start_q     <= 1'b0;
      fp_reg_write_q <= 1'b0;
      halted_q       <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (wait_cnt != WCNT_W'(TIMEOUT))
        wait_cnt <= wait_cnt + 1'b1;
      if (retire)
        retired_q <= retired_q + 1'b1;
      alu_start_q    <= (state_nxt == S_EXEC);
      mem_read_q     <= (state_nxt == S_MEM) && is_ld;
      mem_write_q    <= (state_nxt == S_MEM) && is_st;
      reg_write_q    <= (state_nxt == S_WB) && !is_fp;
      fp_reg_write_q <= (state_nxt == S_WB) && is_fp;
      link_write_q   <= (state_nxt == S_EXEC) && is_j && bus.op[0];
      fp_start_q     <= (state_nxt == S_FP_EXEC) && (state != S_FP_EXEC);
      halted_q       <= (state_nxt == S_HALT) || (state_nxt == S_ERROR);
      error_q        <= (state_nxt == S_ERROR);
    end
  end

  // Handshake-qualified PC/IR strobes depend on live inputs within the cycle.
  always_comb begin
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_src   = 2'd0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          if (bus.imem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          if (is_br) begin
            bus.pc_src   = 2'd1;
            bus.pc_write = bus.branch_taken;
          end else if (is_j) begin
            bus.pc_src   = 2'd2;
            bus.pc_write = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_start    = alu_start_q;
  assign bus.mem_read     = mem_read_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.reg_write    = reg_write_q;
  assign bus.link_write   = link_write_q;
  assign bus.fp_start     = fp_start_q;
  assign bus.fp_reg_write = fp_reg_write_q;
  assign bus.halted       = halted_q;
  assign bus.error        = error_q;
  assign bus.retired      = retired_q;

endmodule
